// File: rtl/bist_checker.sv
// Memory BIST response checker: aligns expected data with delayed read data,
// counts mismatches and captures the context of the first failure.
module bist_checker #(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int CYCLE_WIDTH  = 64,
  parameter int READ_LATENCY = 1,
  parameter int COUNT_WIDTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   clear,
  input  logic                   re,
  input  logic [ADDR_WIDTH-1:0]  addr,
  input  logic [DATA_WIDTH-1:0]  expected,
  input  logic                   pat_done,
  input  logic [3:0]             pattern_sel,
  input  logic [DATA_WIDTH-1:0]  dout,
  output logic                   done,
  output logic                   fail,
  output logic [COUNT_WIDTH-1:0] fail_count,
  output logic [ADDR_WIDTH-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0]  fail_expected,
  output logic [DATA_WIDTH-1:0]  fail_actual,
  output logic [3:0]             fail_pattern,
  output logic [CYCLE_WIDTH-1:0] fail_cycle
);

  localparam int LAST = READ_LATENCY - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   run_cyc;
  logic                   accept;
  logic                   any_vld;
  logic                   mismatch;
  logic [CYCLE_WIDTH-1:0] cycle_cnt;

  logic [READ_LATENCY-1:0] vld_p;
  logic [ADDR_WIDTH-1:0]   addr_p [READ_LATENCY];
  logic [DATA_WIDTH-1:0]   exp_p  [READ_LATENCY];
  logic [3:0]              pat_p  [READ_LATENCY];
  logic [CYCLE_WIDTH-1:0]  cyc_p  [READ_LATENCY];

  function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
    return (&v) ? v : v + COUNT_WIDTH'(1);
  endfunction

  // An enabled IDLE cycle already behaves as a RUN cycle.
  assign run_cyc  = en && ((state == IDLE) || (state == RUN));
  assign accept   = run_cyc && re && !clear;
  assign any_vld  = |vld_p;
  assign mismatch = vld_p[LAST] && (dout != exp_p[LAST]) && !clear;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (en) state_nxt = pat_done ? DRAIN : RUN;
        end
        DRAIN: begin
          if (!any_vld) state_nxt = DONE;
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    done = 1'b0;
    if (state == DONE) done = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
    end else if (clear) begin
      cycle_cnt <= '0;
    end else if (run_cyc) begin
      cycle_cnt <= cycle_cnt + CYCLE_WIDTH'(1);
    end
  end

  // p0..pLAST: request context travelling alongside the outstanding read
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_p <= '0;
    end else if (clear) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= accept;
      for (int i = 1; i < READ_LATENCY; i++) vld_p[i] <= vld_p[i-1];
    end
  end

  always_ff @(posedge clk) begin
    addr_p[0] <= addr;
    exp_p[0]  <= expected;
    pat_p[0]  <= pattern_sel;
    cyc_p[0]  <= cycle_cnt;
    for (int i = 1; i < READ_LATENCY; i++) begin
      addr_p[i] <= addr_p[i-1];
      exp_p[i]  <= exp_p[i-1];
      pat_p[i]  <= pat_p[i-1];
      cyc_p[i]  <= cyc_p[i-1];
    end
  end

  // Compare stage: first failure is frozen, later ones only bump the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      fail_pattern  <= '0;
      fail_cycle    <= '0;
    end else if (clear) begin
      fail          <= 1'b0;
      fail_addr     <= '0;
      fail_expected <= '0;
      fail_actual   <= '0;
      fail_pattern  <= '0;
      fail_cycle    <= '0;
    end else if (mismatch && !fail) begin
      fail          <= 1'b1;
      fail_addr     <= addr_p[LAST];
      fail_expected <= exp_p[LAST];
      fail_actual   <= dout;
      fail_pattern  <= pat_p[LAST];
      fail_cycle    <= cyc_p[LAST];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fail_count <= '0;
    end else if (clear) begin
      fail_count <= '0;
    end else if (mismatch) begin
      fail_count <= sat_inc(fail_count);
    end
  end

endmodule

// File: tb/tb_bist_checker.sv
// Bench for bist_checker: one instance at read latency 1 and one at 3 share
// the stimulus; each gets its own delayed read-data responder and scoreboard.
module tb_bist_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, en, clear, re, pat_done;
  logic [7:0]  addr;
  logic [31:0] expected, dout1, dout3;
  logic [3:0]  pattern_sel;

  logic        done1, fail1, done3, fail3;
  logic [15:0] cnt1, cnt3;
  logic [7:0]  faddr1, faddr3;
  logic [31:0] fexp1, fact1, fexp3, fact3;
  logic [3:0]  fpat1, fpat3;
  logic [63:0] fcyc1, fcyc3;

  bist_checker #(.READ_LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst_n), .en(en), .clear(clear), .re(re), .addr(addr),
    .expected(expected), .pat_done(pat_done), .pattern_sel(pattern_sel), .dout(dout1),
    .done(done1), .fail(fail1), .fail_count(cnt1), .fail_addr(faddr1),
    .fail_expected(fexp1), .fail_actual(fact1), .fail_pattern(fpat1), .fail_cycle(fcyc1)
  );

  bist_checker #(.READ_LATENCY(3)) u_dut3 (
    .clk(clk), .rst(rst_n), .en(en), .clear(clear), .re(re), .addr(addr),
    .expected(expected), .pat_done(pat_done), .pattern_sel(pattern_sel), .dout(dout3),
    .done(done3), .fail(fail3), .fail_count(cnt3), .fail_addr(faddr3),
    .fail_expected(fexp3), .fail_actual(fact3), .fail_pattern(fpat3), .fail_cycle(fcyc3)
  );

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
    logic [31:0] act;
    logic [3:0]  pat;
    logic [63:0] cyc;
    int          due;
  } rd_t;

  rd_t q1[$];
  rd_t q3[$];

  int          ncmp = 0;
  int          nfail = 0;
  int          k = 0;
  int          kmark;
  logic        run_phase;
  logic [63:0] ccount;

  logic [15:0] m_cnt  [2];
  logic        m_fail [2];
  logic [7:0]  m_addr [2];
  logic [31:0] m_exp  [2];
  logic [31:0] m_act  [2];
  logic [3:0]  m_pat  [2];
  logic [63:0] m_cyc  [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    q1.delete();
    q3.delete();
    run_phase = 1'b1;
    ccount = '0;
    for (int d = 0; d < 2; d++) begin
      m_cnt[d] = '0; m_fail[d] = 1'b0; m_addr[d] = '0; m_exp[d] = '0;
      m_act[d] = '0; m_pat[d] = '0; m_cyc[d] = '0;
    end
  endtask

  task automatic retire(input int d, input rd_t e);
    logic [63:0] oc, of, oa, oe, ot, op, oy;
    if (e.act != e.exp) begin
      if (m_cnt[d] != 16'hFFFF) m_cnt[d] = m_cnt[d] + 16'd1;
      if (!m_fail[d]) begin
        m_fail[d] = 1'b1; m_addr[d] = e.addr; m_exp[d] = e.exp;
        m_act[d] = e.act; m_pat[d] = e.pat; m_cyc[d] = e.cyc;
      end
    end
    if (d == 0) begin
      oc = 64'(cnt1); of = 64'(fail1); oa = 64'(faddr1); oe = 64'(fexp1);
      ot = 64'(fact1); op = 64'(fpat1); oy = fcyc1;
    end else begin
      oc = 64'(cnt3); of = 64'(fail3); oa = 64'(faddr3); oe = 64'(fexp3);
      ot = 64'(fact3); op = 64'(fpat3); oy = fcyc3;
    end
    chk($sformatf("sb%0d_count_a%0h", d, e.addr), oc, 64'(m_cnt[d]));
    chk($sformatf("sb%0d_fail_a%0h", d, e.addr), of, 64'(m_fail[d]));
    chk($sformatf("sb%0d_faddr_a%0h", d, e.addr), oa, 64'(m_addr[d]));
    chk($sformatf("sb%0d_fexp_a%0h", d, e.addr), oe, 64'(m_exp[d]));
    chk($sformatf("sb%0d_fact_a%0h", d, e.addr), ot, 64'(m_act[d]));
    chk($sformatf("sb%0d_fpat_a%0h", d, e.addr), op, 64'(m_pat[d]));
    chk($sformatf("sb%0d_fcyc_a%0h", d, e.addr), oy, m_cyc[d]);
  endtask

  task automatic step(input logic s_en, input logic s_re, input logic [7:0] s_addr,
                      input logic [31:0] s_exp, input logic [31:0] s_act,
                      input logic s_pd, input logic [3:0] s_pat);
    rd_t e;
    en = s_en; re = s_re; addr = s_addr; expected = s_exp;
    pat_done = s_pd; pattern_sel = s_pat;
    if (run_phase && s_en && s_re) begin
      e.addr = s_addr; e.exp = s_exp; e.act = s_act; e.pat = s_pat; e.cyc = ccount;
      e.due = k + 1; q1.push_back(e);
      e.due = k + 3; q3.push_back(e);
    end
    dout1 = 32'hDEAD_BEEF;
    dout3 = 32'hDEAD_BEEF;
    if (q1.size() > 0 && q1[0].due == k) dout1 = q1[0].act;
    if (q3.size() > 0 && q3[0].due == k) dout3 = q3[0].act;
    @(posedge clk); #1;
    if (q1.size() > 0 && q1[0].due == k) retire(0, q1.pop_front());
    if (q3.size() > 0 && q3[0].due == k) retire(1, q3.pop_front());
    if (run_phase && s_en) begin
      ccount = ccount + 64'd1;
      if (s_pd) run_phase = 1'b0;
    end
    k++;
  endtask

  task automatic idle(input int n, input logic s_en);
    for (int i = 0; i < n; i++) step(s_en, 1'b0, 8'h00, 32'h0, 32'h0, 1'b0, 4'h0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_done1"}, 64'(done1), 64'd0);
    chk({tag, "_fail1"}, 64'(fail1), 64'd0);
    chk({tag, "_cnt1"},  64'(cnt1),  64'd0);
    chk({tag, "_faddr1"}, 64'(faddr1), 64'd0);
    chk({tag, "_fact1"}, 64'(fact1), 64'd0);
    chk({tag, "_fexp1"}, 64'(fexp1), 64'd0);
    chk({tag, "_fpat1"}, 64'(fpat1), 64'd0);
    chk({tag, "_fcyc1"}, fcyc1, 64'd0);
    chk({tag, "_done3"}, 64'(done3), 64'd0);
    chk({tag, "_fail3"}, 64'(fail3), 64'd0);
    chk({tag, "_cnt3"},  64'(cnt3),  64'd0);
    chk({tag, "_faddr3"}, 64'(faddr3), 64'd0);
    chk({tag, "_fact3"}, 64'(fact3), 64'd0);
    chk({tag, "_fcyc3"}, fcyc3, 64'd0);
  endtask

  // Clear is asserted together with a live request and pat_done to prove priority.
  task automatic do_clear(input string tag);
    en = 1'b1; re = 1'b1; addr = 8'hFF; expected = 32'h0; pat_done = 1'b1;
    dout1 = 32'h1; dout3 = 32'h1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; en = 1'b0; re = 1'b0; pat_done = 1'b0;
    reset_model();
    k++;
    check_zero(tag);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; clear = 1'b0; re = 1'b0; pat_done = 1'b0;
    addr = '0; expected = '0; pattern_sel = '0; dout1 = '0; dout3 = '0;
    reset_model();
    #12;
    check_zero("reset");
    rst_n = 1'b1;

    // All reads match; done timing depends on latency.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 8'(i), 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0, 4'h1);
    step(1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 4'h1);
    chk("pass_done1_pd", 64'(done1), 64'd0);
    idle(1, 1'b0);
    chk("pass_done1_2cyc", 64'(done1), 64'd1);
    chk("pass_done3_early", 64'(done3), 64'd0);
    idle(1, 1'b0);
    chk("pass_done3_mid", 64'(done3), 64'd0);
    idle(1, 1'b0);
    chk("pass_done3", 64'(done3), 64'd1);
    chk("pass_fail1", 64'(fail1), 64'd0);
    chk("pass_cnt3", 64'(cnt3), 64'd0);
    do_clear("clear_a");

    // Single mismatch at addr 5, cycle 7.
    idle(7, 1'b1);
    step(1'b1, 1'b1, 8'h05, 32'h0, 32'h10, 1'b0, 4'h3);
    idle(3, 1'b0);
    chk("one_fail1", 64'(fail1), 64'd1);
    chk("one_faddr1", 64'(faddr1), 64'd5);
    chk("one_fact1", 64'(fact1), 64'h10);
    chk("one_fcyc1", fcyc1, 64'd7);
    chk("one_cnt1", 64'(cnt1), 64'd1);
    chk("one_faddr3", 64'(faddr3), 64'd5);
    chk("one_fcyc3", fcyc3, 64'd7);
    chk("one_fpat3", 64'(fpat3), 64'd3);
    do_clear("clear_b");

    // en=0 reads are ignored and do not advance the counter; first failure is kept.
    idle(2, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h07, 32'h0, 32'hFF, 1'b0, 4'h8);
    step(1'b1, 1'b1, 8'h02, 32'h1, 32'h2, 1'b0, 4'h4);
    step(1'b1, 1'b1, 8'h09, 32'h3, 32'h4, 1'b0, 4'h5);
    step(1'b1, 1'b0, 8'h00, 32'h0, 32'h0, 1'b1, 4'h5);
    idle(4, 1'b0);
    chk("two_faddr1", 64'(faddr1), 64'd2);
    chk("two_cnt1", 64'(cnt1), 64'd2);
    chk("two_faddr3", 64'(faddr3), 64'd2);
    chk("two_fcyc3", fcyc3, 64'd2);
    chk("two_cnt3", 64'(cnt3), 64'd2);
    chk("two_done3", 64'(done3), 64'd1);
    step(1'b1, 1'b1, 8'h33, 32'h0, 32'hF, 1'b1, 4'h6);
    step(1'b1, 1'b1, 8'h34, 32'h0, 32'hF, 1'b1, 4'h6);
    idle(3, 1'b0);
    chk("done_ignore_cnt1", 64'(cnt1), 64'd2);
    chk("done_ignore_cnt3", 64'(cnt3), 64'd2);
    chk("done_hold1", 64'(done1), 64'd1);
    do_clear("clear_c");

    // Last read issued with pat_done and mismatching: caught during DRAIN.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'(i), 32'h11, 32'h11, 1'b0, 4'h2);
    kmark = k;
    step(1'b1, 1'b1, 8'h03, 32'h11, 32'h22, 1'b1, 4'h2);
    idle(1, 1'b0);
    chk("drain_fail1", 64'(fail1), 64'd1);
    chk("drain_done1_low", 64'(done1), 64'd0);
    chk("drain_fail3_early", 64'(fail3), 64'd0);
    idle(1, 1'b0);
    chk("drain_done1", 64'(done1), 64'd1);
    chk("drain_fail3_mid", 64'(fail3), 64'd0);
    idle(1, 1'b0);
    chk("drain_fail3", 64'(fail3), 64'd1);
    chk("drain_done3_low", 64'(done3), 64'd0);
    idle(1, 1'b0);
    chk("drain_done3", 64'(done3), 64'd1);
    chk("drain_faddr3", 64'(faddr3), 64'd3);
    chk("drain_fcyc3", fcyc3, 64'(kmark - kmark + 3));
    do_clear("clear_d");

    // Asynchronous reset during DRAIN with a mismatch still in flight.
    step(1'b1, 1'b1, 8'h04, 32'h0, 32'h1, 1'b0, 4'h7);
    step(1'b1, 1'b1, 8'h06, 32'h0, 32'h2, 1'b1, 4'h7);
    idle(2, 1'b0);
    chk("prerst_fail3", 64'(fail3), 64'd1);
    chk("prerst_cnt1", 64'(cnt1), 64'd2);
    rst_n = 1'b0;
    #1;
    check_zero("async_rst");
    @(posedge clk); #1;
    rst_n = 1'b1;
    reset_model();
    k++;
    for (int i = 0; i < 5; i++) begin
      en = 1'b0; re = 1'b0; pat_done = 1'b0;
      dout1 = 32'h5555_0000; dout3 = 32'h5555_0000;
      @(posedge clk); #1;
      k++;
    end
    chk("postrst_fail1", 64'(fail1), 64'd0);
    chk("postrst_fail3", 64'(fail3), 64'd0);
    chk("postrst_cnt3", 64'(cnt3), 64'd0);
    chk("postrst_done3", 64'(done3), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
